// File: rtl/square_sqrt.sv
// Sequential digit-by-digit square root: floor(sqrt(din)) and remainder,
// one root bit per cycle, valid/ready on both sides. Negative din flags err.
module square_sqrt #(
  parameter int unsigned W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W+1:0]   din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       dout,
  output logic [W+1:0]     dout_rem,
  output logic             err
);

  localparam int unsigned DW    = 2 * W + 2;
  localparam int unsigned TW    = W + 3;
  localparam int unsigned CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  // Partial root/remainder stay below 2^W / 2^(W+1) until the final iteration,
  // whose full-width result goes straight into the output registers.
  logic [DW-1:0]      r_din;
  logic [W-1:0]       r_root;
  logic [W:0]         r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               r_out_valid;
  logic [W:0]         r_dout;
  logic [W+1:0]       r_dout_rem;

  logic [TW-1:0]      w_acc;
  logic [TW-1:0]      w_sub;
  logic [TW-1:0]      w_trial;
  logic               w_bit;
  logic [W:0]         w_root_nxt;
  logic [W+1:0]       w_rem_nxt;

  // One iteration: trial = {rem, next pair} - {root, 01}
  assign w_acc      = {r_rem, r_din[DW-1 -: 2]};
  assign w_sub      = TW'({r_root, 2'b01});
  assign w_trial    = w_acc - w_sub;
  assign w_bit      = ~w_trial[TW-1];
  assign w_root_nxt = {r_root, w_bit};
  assign w_rem_nxt  = w_bit ? w_trial[W+1:0] : w_acc[W+1:0];
  assign w_last     = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_CALC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din       <= '0;
      r_root      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_dout_rem  <= '0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_din  <= din;
        r_root <= '0;
        r_rem  <= '0;
        r_cnt  <= CNT_W'(W);
        r_err  <= din[DW-1];
      end else if (r_state == S_CALC) begin
        r_din  <= {r_din[DW-3:0], 2'b00};
        r_root <= w_root_nxt[W-1:0];
        r_rem  <= w_rem_nxt[W:0];
        if (w_last) begin
          r_dout     <= r_err ? '0 : w_root_nxt;
          r_dout_rem <= r_err ? '0 : w_rem_nxt;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign dout_rem  = r_dout_rem;
  assign err       = r_err;

endmodule

// File: tb/tb_square_sqrt.sv
// Self-checking bench for square_sqrt: integer-sqrt model plus a cycle-timing
// model of the handshake, compared every cycle.
module tb_square_sqrt;

  localparam int unsigned W  = 17;
  localparam int unsigned DW = 2 * W + 2;
  localparam int unsigned LAT = W + 1;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   din;
  logic            out_valid;
  logic            out_ready;
  logic [W:0]      dout;
  logic [W+1:0]    dout_rem;
  logic            err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  square_sqrt #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .dout_rem  (dout_rem),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: exact integer square root by binary search on plain integers.
  function automatic void model(input logic [DW-1:0] d, output longint r,
                                output longint m, output logic e);
    longint v, lo, hi, mid;
    if (d[DW-1]) begin
      r = 0; m = 0; e = 1'b1;
    end else begin
      v  = longint'({28'b0, d});
      lo = 0;
      hi = longint'(1) << (W + 1);
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mid * mid <= v) lo = mid;
        else hi = mid;
      end
      r = lo; m = v - lo * lo; e = 1'b0;
    end
  endfunction

  typedef struct {
    longint r;
    longint m;
    logic   e;
    int     t0;
  } exp_t;

  exp_t q[$];
  logic last_err = 1'b0;

  // Per-cycle compare against the timing + value model
  always @(negedge clk) begin
    logic exp_rdy, exp_ov;
    exp_t  x;
    if (rst) begin
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_dout", longint'(dout), 0);
      chk("rst_rem", longint'(dout_rem), 0);
      chk("rst_err", longint'(err), 0);
      q.delete();
      last_err = 1'b0;
    end else begin
      exp_ov = (q.size() != 0) && (cyc >= q[0].t0 + int'(LAT));
      if (q.size() == 0) exp_rdy = 1'b1;
      else if (!exp_ov) exp_rdy = 1'b0;
      else exp_rdy = out_ready;
      chk("in_ready", longint'(in_ready), longint'(exp_rdy));
      chk("out_valid", longint'(out_valid), longint'(exp_ov));
      chk("err", longint'(err), longint'(last_err));
      if (exp_ov) begin
        chk("dout", longint'(dout), q[0].r);
        chk("dout_rem", longint'(dout_rem), q[0].m);
        if (out_ready) q.delete(0);
      end
      if (in_valid && exp_rdy) begin
        model(din, x.r, x.m, x.e);
        x.t0 = cyc + 1;
        q.push_back(x);
        last_err = x.e;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [DW-1:0] d);
    int n = 0;
    while (!in_ready && n < 60) begin tick(); n++; end
    if (n >= 60) chk("timeout_in_ready", 0, 1);
    in_valid = 1'b1;
    din      = d;
    tick();
    in_valid = 1'b0;
    din      = 'x;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    if (n >= 40) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic pop(input int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [DW-1:0] d, input int hold);
    issue(d);
    wait_valid();
    pop(hold);
  endtask

  // Hand-computed anchors for the model itself
  initial begin
    longint r, m;
    logic   e;
    model(DW'(200), r, m, e);          chk("pin200_r", r, 14); chk("pin200_m", m, 4);
    model(DW'(1), r, m, e);            chk("pin1_r", r, 1);    chk("pin1_m", m, 0);
    model(DW'(3), r, m, e);            chk("pin3_m", m, 2);
    model(DW'(64'd8589934592), r, m, e);
    chk("pinbig_r", r, 92681);         chk("pinbig_m", m, 166831);
    model('1, r, m, e);                chk("pinneg_e", longint'(e), 1);
    model(DW'(49), r, m, e);           chk("pin49_r", r, 7);
  end

  initial begin
    logic [DW-1:0] v;
    int a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run(DW'(0), 0);
    run(DW'(200), 0);
    run(DW'(1), 0);
    run(DW'(3), 0);
    run(DW'(64'd8589934592), 0);
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(20)) - 10;
      b = int'($urandom_range(40)) - 20;
      run(DW'(a * a + b * b), int'($urandom_range(2)));
    end
    for (int i = 0; i < 4; i++) begin
      v = {1'b0, 3'($urandom), $urandom};
      run(v, 0);
    end
    run(DW'(64'h7_FFFF_FFFF), 0);

    // Negative input, held with backpressure, then back-to-back accept
    issue('1);
    wait_valid();
    repeat (5) tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    din       = DW'(16);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    din       = 'x;
    wait_valid();
    pop(0);

    // Reset mid-calculation discards the result
    issue(DW'(200));
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (25) tick();
    run(DW'(49), 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
